uart_cmd_initiator: RTL and testbench

Host-side command initiator for the UART temperature/heater control protocol. It drives an external byte-level `tx`/`rx` pair. It issues start (0x30), stop (0x31), reset (0x40) and temperature-poll (0x2F) commands, then waits for and checks each single-byte response against the expected value. The block runs periodic temperature polling, tracks remote heater state and counts protocol errors. It is the initiator end of the link whose responder answers 0x41/0x42/0x52/temperature.

---
 rtl/uart_cmd_initiator.sv | 219 +++++++++++++++++++++
 tb/tb_uart_cmd_initiator.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_initiator.sv
// Host-side initiator for the UART heater/temperature protocol: queues start, stop,
// reset and periodic poll commands, sends one at a time and checks each reply byte.
module uart_cmd_initiator #(
  parameter int POLL_PERIOD    = 100_000_000,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_reset,
  input  logic       poll_en,
  output logic [7:0] tx_din,
  output logic       tx_send,
  input  logic       tx_sent,
  input  logic       rx_receive,
  input  logic [7:0] rx_dout,
  input  logic       rx_parity_err,
  output logic       rx_received,
  output logic [6:0] temperature,
  output logic       temp_valid,
  output logic       heater_on,
  output logic       busy,
  output logic       err_pulse,
  output logic [7:0] err_count
);

  localparam int PW = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_START = 8'h30;
  localparam logic [7:0] CMD_STOP  = 8'h31;
  localparam logic [7:0] CMD_RESET = 8'h40;
  localparam logic [7:0] CMD_POLL  = 8'h2F;
  localparam logic [7:0] RSP_START = 8'h41;
  localparam logic [7:0] RSP_STOP  = 8'h42;
  localparam logic [7:0] RSP_RESET = 8'h52;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_SENT,
    S_WAIT_RESP
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_pend_start, r_pend_stop, r_pend_reset, r_pend_poll;
  logic [PW-1:0] r_poll_cnt;
  logic [TW-1:0] r_to_cnt, w_to_cnt_nxt;
  logic [7:0]    r_tx_din, w_tx_din_nxt;
  logic [7:0]    r_exp_resp, w_exp_resp_nxt;
  logic          r_is_poll, w_is_poll_nxt;
  logic          r_rx_received, w_rx_received_nxt;
  logic [6:0]    r_temperature, w_temperature_nxt;
  logic          r_temp_valid, w_temp_valid_nxt;
  logic          r_heater_on, w_heater_on_nxt;
  logic          r_err_pulse, w_err_nxt;
  logic [7:0]    r_err_count;
  logic          w_launch_start, w_launch_stop, w_launch_reset, w_launch_poll;
  logic          w_byte;
  logic          w_poll_wrap;

  // A byte still presented during the ack cycle belongs to the previous handshake.
  assign w_byte      = rx_receive & ~r_rx_received;
  assign w_poll_wrap = poll_en && (r_poll_cnt == POLL_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always blocks are evaluated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_start <= 1'b0;
      r_pend_stop  <= 1'b0;
      r_pend_reset <= 1'b0;
      r_pend_poll  <= 1'b0;
      r_poll_cnt   <= '0;
    end else begin
      // A new pulse wins over a same-cycle launch so the request is never dropped.
      r_pend_start <= cmd_start | (r_pend_start & ~w_launch_start);
      r_pend_stop  <= cmd_stop  | (r_pend_stop  & ~w_launch_stop);
      r_pend_reset <= cmd_reset | (r_pend_reset & ~w_launch_reset);
      if (!poll_en) begin
        r_poll_cnt  <= '0;
        r_pend_poll <= 1'b0;
      end else begin
        r_poll_cnt  <= w_poll_wrap ? '0 : r_poll_cnt + PW'(1);
        r_pend_poll <= w_poll_wrap | (r_pend_poll & ~w_launch_poll);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_to_cnt      <= '0;
      r_tx_din      <= 8'h00;
      r_exp_resp    <= 8'h00;
      r_is_poll     <= 1'b0;
      r_rx_received <= 1'b0;
      r_temperature <= 7'h00;
      r_temp_valid  <= 1'b0;
      r_heater_on   <= 1'b0;
      r_err_pulse   <= 1'b0;
      r_err_count   <= 8'h00;
    end else begin
      r_state       <= w_state_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
      r_tx_din      <= w_tx_din_nxt;
      r_exp_resp    <= w_exp_resp_nxt;
      r_is_poll     <= w_is_poll_nxt;
      r_rx_received <= w_rx_received_nxt;
      r_temperature <= w_temperature_nxt;
      r_temp_valid  <= w_temp_valid_nxt;
      r_heater_on   <= w_heater_on_nxt;
      r_err_pulse   <= w_err_nxt;
      if (w_err_nxt && (r_err_count != 8'hFF))
        r_err_count <= r_err_count + 8'd1;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt       = r_state;
    w_to_cnt_nxt      = r_to_cnt;
    w_tx_din_nxt      = r_tx_din;
    w_exp_resp_nxt    = r_exp_resp;
    w_is_poll_nxt     = r_is_poll;
    w_rx_received_nxt = 1'b0;
    w_temperature_nxt = r_temperature;
    w_temp_valid_nxt  = 1'b0;
    w_heater_on_nxt   = r_heater_on;
    w_err_nxt         = 1'b0;
    w_launch_start    = 1'b0;
    w_launch_stop     = 1'b0;
    w_launch_reset    = 1'b0;
    w_launch_poll     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_rx_received_nxt = w_byte;
        if (r_pend_reset) begin
          w_launch_reset = 1'b1;
          w_tx_din_nxt   = CMD_RESET;
          w_exp_resp_nxt = RSP_RESET;
          w_is_poll_nxt  = 1'b0;
          w_state_nxt    = S_SEND;
        end else if (r_pend_stop) begin
          w_launch_stop  = 1'b1;
          w_tx_din_nxt   = CMD_STOP;
          w_exp_resp_nxt = RSP_STOP;
          w_is_poll_nxt  = 1'b0;
          w_state_nxt    = S_SEND;
        end else if (r_pend_start) begin
          w_launch_start = 1'b1;
          w_tx_din_nxt   = CMD_START;
          w_exp_resp_nxt = RSP_START;
          w_is_poll_nxt  = 1'b0;
          w_state_nxt    = S_SEND;
        end else if (r_pend_poll) begin
          w_launch_poll  = 1'b1;
          w_tx_din_nxt   = CMD_POLL;
          w_exp_resp_nxt = 8'h00;
          w_is_poll_nxt  = 1'b1;
          w_state_nxt    = S_SEND;
        end
      end
      S_SEND: begin
        w_rx_received_nxt = w_byte;
        if (tx_sent) w_state_nxt = S_WAIT_SENT;
      end
      S_WAIT_SENT: begin
        w_rx_received_nxt = w_byte;
        if (!tx_sent) begin
          w_to_cnt_nxt = '0;
          w_state_nxt  = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        w_to_cnt_nxt = r_to_cnt + TW'(1);
        if (w_byte) begin
          w_rx_received_nxt = 1'b1;
          w_state_nxt       = S_IDLE;
          if (rx_parity_err) begin
            w_err_nxt = 1'b1;
          end else if (r_is_poll) begin
            if (rx_dout[7]) begin
              w_err_nxt = 1'b1;
            end else begin
              w_temperature_nxt = rx_dout[6:0];
              w_temp_valid_nxt  = 1'b1;
            end
          end else if (rx_dout == r_exp_resp) begin
            w_heater_on_nxt = (r_exp_resp == RSP_START);
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (r_to_cnt == TO_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Decoded from the state register so it drops as soon as reset clears the state.
  assign tx_send     = (r_state == S_SEND);
  assign busy        = (r_state != S_IDLE);
  assign tx_din      = r_tx_din;
  assign rx_received = r_rx_received;
  assign temperature = r_temperature;
  assign temp_valid  = r_temp_valid;
  assign heater_on   = r_heater_on;
  assign err_pulse   = r_err_pulse;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// Directed bench for uart_cmd_initiator: a vector table of command/reply pairs plus
// hand-written sequences for latency, priority, timeout, reset abort and saturation.
module tb_uart_cmd_initiator;

  localparam int POLL_PERIOD    = 16;
  localparam int TIMEOUT_CYCLES = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_start, cmd_stop, cmd_reset, poll_en;
  logic [7:0] tx_din;
  logic       tx_send, tx_sent;
  logic       rx_receive;
  logic [7:0] rx_dout;
  logic       rx_parity_err, rx_received;
  logic [6:0] temperature;
  logic       temp_valid, heater_on, busy, err_pulse;
  logic [7:0] err_count;

  uart_cmd_initiator #(
    .POLL_PERIOD   (POLL_PERIOD),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_start    (cmd_start),
    .cmd_stop     (cmd_stop),
    .cmd_reset    (cmd_reset),
    .poll_en      (poll_en),
    .tx_din       (tx_din),
    .tx_send      (tx_send),
    .tx_sent      (tx_sent),
    .rx_receive   (rx_receive),
    .rx_dout      (rx_dout),
    .rx_parity_err(rx_parity_err),
    .rx_received  (rx_received),
    .temperature  (temperature),
    .temp_valid   (temp_valid),
    .heater_on    (heater_on),
    .busy         (busy),
    .err_pulse    (err_pulse),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Pulse/ack counters sampled on the falling edge.
  int   n_err_p  = 0;
  int   n_tv     = 0;
  int   n_ack    = 0;
  int   n_double = 0;
  logic prev_ack = 1'b0;

  always @(negedge clk) begin
    if (err_pulse)  n_err_p <= n_err_p + 1;
    if (temp_valid) n_tv    <= n_tv + 1;
    if (rx_received) n_ack  <= n_ack + 1;
    if (rx_received && prev_ack) n_double <= n_double + 1;
    prev_ack <= rx_received;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [2:0] m);  // {reset, stop, start}
    @(posedge clk); #1;
    {cmd_reset, cmd_stop, cmd_start} = m;
    @(posedge clk); #1;
    {cmd_reset, cmd_stop, cmd_start} = 3'b000;
  endtask

  // Plays the tx block: waits for tx_send, captures the byte, completes the handshake.
  task automatic handshake(output logic [7:0] sent);
    sent = 8'h00;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_send) break;
    end
    if (!tx_send) begin
      check("tx_send_wait", {31'd0, tx_send}, 32'd1);
      return;
    end
    sent    = tx_din;
    poll_en = 1'b0;
    @(posedge clk); #1;
    tx_sent = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!tx_send) break;
    end
    check("tx_send_drop", {31'd0, tx_send}, 32'd0);
    @(posedge clk); #1;
    tx_sent = 1'b0;
  endtask

  // Plays the rx block: presents a byte and holds it until acknowledged.
  task automatic reply(input logic [7:0] b, input logic par);
    @(posedge clk); #1;
    rx_receive    = 1'b1;
    rx_dout       = b;
    rx_parity_err = par;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rx_received) break;
    end
    check("rx_ack_wait", {31'd0, rx_received}, 32'd1);
    @(posedge clk); #1;
    rx_receive    = 1'b0;
    rx_parity_err = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("busy_wait", {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0] cmd;        // {reset, stop, start}; 0 means poll
    logic [7:0] reply;
    logic       par;
    logic [7:0] exp_tx;
    logic       exp_heater;
    logic [7:0] exp_errs;
    logic [6:0] exp_temp;
    logic       exp_tv;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [7:0] sent;
    int e0, t0, a0, k;

    vecs[0]  = '{3'b000, 8'h35, 1'b0, 8'h2F, 1'b0, 8'd0, 7'h35, 1'b1};
    vecs[1]  = '{3'b001, 8'h41, 1'b0, 8'h30, 1'b1, 8'd0, 7'h35, 1'b0};
    vecs[2]  = '{3'b010, 8'h42, 1'b0, 8'h31, 1'b0, 8'd0, 7'h35, 1'b0};
    vecs[3]  = '{3'b001, 8'h42, 1'b0, 8'h30, 1'b0, 8'd1, 7'h35, 1'b0};
    vecs[4]  = '{3'b000, 8'h85, 1'b0, 8'h2F, 1'b0, 8'd2, 7'h35, 1'b0};
    vecs[5]  = '{3'b100, 8'h52, 1'b0, 8'h40, 1'b0, 8'd2, 7'h35, 1'b0};
    vecs[6]  = '{3'b001, 8'h41, 1'b1, 8'h30, 1'b0, 8'd3, 7'h35, 1'b0};
    vecs[7]  = '{3'b000, 8'h7F, 1'b0, 8'h2F, 1'b0, 8'd3, 7'h7F, 1'b1};
    vecs[8]  = '{3'b001, 8'h41, 1'b0, 8'h30, 1'b1, 8'd3, 7'h7F, 1'b0};
    vecs[9]  = '{3'b100, 8'h41, 1'b0, 8'h40, 1'b1, 8'd4, 7'h7F, 1'b0};
    vecs[10] = '{3'b100, 8'h52, 1'b0, 8'h40, 1'b0, 8'd4, 7'h7F, 1'b0};

    reset = 1'b1;
    {cmd_reset, cmd_stop, cmd_start} = 3'b000;
    poll_en = 1'b0; tx_sent = 1'b0;
    rx_receive = 1'b0; rx_dout = 8'h00; rx_parity_err = 1'b0;
    #1;
    check("rst_tx_din", {24'd0, tx_din}, 32'h00);
    check("rst_outputs", {25'd0, tx_send, rx_received, temp_valid, heater_on, busy,
                          err_pulse, 1'b0}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    check("rst_temperature", {25'd0, temperature}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 11; v++) begin
      e0 = n_err_p; t0 = n_tv; a0 = n_ack;
      if (vecs[v].cmd == 3'b000) begin
        @(posedge clk); #1 poll_en = 1'b1;
      end else begin
        pulse(vecs[v].cmd);
      end
      handshake(sent);
      reply(vecs[v].reply, vecs[v].par);
      wait_idle();
      check($sformatf("v%0d_tx_byte", v), {24'd0, sent}, {24'd0, vecs[v].exp_tx});
      check($sformatf("v%0d_heater", v), {31'd0, heater_on}, {31'd0, vecs[v].exp_heater});
      check($sformatf("v%0d_err_count", v), {24'd0, err_count}, {24'd0, vecs[v].exp_errs});
      check($sformatf("v%0d_temperature", v), {25'd0, temperature}, {25'd0, vecs[v].exp_temp});
      check($sformatf("v%0d_tv_pulses", v), n_tv - t0, {31'd0, vecs[v].exp_tv});
      check($sformatf("v%0d_err_pulses", v), n_err_p - e0,
            (v == 0) ? 32'(vecs[v].exp_errs) : 32'(vecs[v].exp_errs - vecs[v - 1].exp_errs));
      check($sformatf("v%0d_acks", v), n_ack - a0, 32'd1);
    end

    // Latency: pulse sampled at edge E1, tx_send and tx_din valid after E2.
    pulse(3'b001);
    @(negedge clk);
    check("lat_n1_tx_send", {31'd0, tx_send}, 32'd0);
    @(negedge clk);
    check("lat_n2_tx_send", {31'd0, tx_send}, 32'd1);
    check("lat_n2_tx_din", {24'd0, tx_din}, 32'h30);
    handshake(sent);
    reply(8'h41, 1'b0);
    wait_idle();
    check("lat_heater", {31'd0, heater_on}, 32'd1);

    // Priority: all three in one cycle go out reset, stop, start.
    pulse(3'b111);
    handshake(sent); check("prio_1st", {24'd0, sent}, 32'h40); reply(8'h52, 1'b0);
    handshake(sent); check("prio_2nd", {24'd0, sent}, 32'h31); reply(8'h42, 1'b0);
    handshake(sent); check("prio_3rd", {24'd0, sent}, 32'h30); reply(8'h41, 1'b0);
    wait_idle();
    check("prio_heater", {31'd0, heater_on}, 32'd1);
    check("prio_err_count", {24'd0, err_count}, 32'd4);

    // Timeout: entry to WAIT_RESP one edge after tx_sent drops, error TIMEOUT_CYCLES later.
    e0 = n_err_p;
    pulse(3'b001);
    handshake(sent);
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      if (err_pulse) break;
      k++;
    end
    check("to_latency", k, 32'(TIMEOUT_CYCLES + 1));
    @(negedge clk);
    check("to_idle", {31'd0, busy}, 32'd0);
    check("to_err_count", {24'd0, err_count}, 32'd5);
    check("to_heater_kept", {31'd0, heater_on}, 32'd1);

    // Unsolicited byte in IDLE: acknowledged, not an error.
    e0 = n_err_p; a0 = n_ack;
    reply(8'h99, 1'b0);
    repeat (3) @(negedge clk);
    check("unsol_ack", n_ack - a0, 32'd1);
    check("unsol_no_err", n_err_p - e0, 32'd0);
    check("unsol_idle", {31'd0, busy}, 32'd0);

    // Reset while tx_send is high clears everything without waiting for a clock edge.
    pulse(3'b001);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_send) break;
    end
    check("rst_mid_send_seen", {31'd0, tx_send}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_tx_send", {31'd0, tx_send}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_heater", {31'd0, heater_on}, 32'd0);
    check("rst_mid_err_count", {24'd0, err_count}, 32'd0);
    check("rst_mid_tx_din", {24'd0, tx_din}, 32'h00);
    check("rst_mid_temperature", {25'd0, temperature}, 32'd0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_relaunch", {31'd0, busy}, 32'd0);

    // Saturation: 300 timeouts must pin the counter at 255.
    for (int n = 0; n < 300; n++) begin
      pulse(3'b001);
      handshake(sent);
      wait_idle();
      if (n == 254) check("sat_at_255", {24'd0, err_count}, 32'd255);
    end
    check("sat_err_count", {24'd0, err_count}, 32'd255);
    check("double_acks", n_double, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
